// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue slice: opcodes, register-file sizing, helpers.
package alu_issue_pkg;

   localparam int unsigned DATA_W    = 32;
   localparam int unsigned NREGS_DEF = 8;

   typedef enum logic [1:0] {
      ALU_OR  = 2'd0,
      ALU_AND = 2'd1,
      ALU_ADD = 2'd2,
      ALU_SUB = 2'd3
   } op_code_e;

   // Index width for a register file of n entries (at least one bit).
   function automatic int unsigned reg_aw(input int unsigned n);
      return (n > 1) ? int'($clog2(n)) : 1;
   endfunction

   localparam int unsigned REG_AW = reg_aw(NREGS_DEF);

endpackage

// File: rtl/alu_issue_reg_file.sv
// Architectural register file: two combinational read ports, one write port, r0 reads zero.
module reg_file
   import alu_issue_pkg::*;
#(
   parameter  int unsigned NREGS = NREGS_DEF,
   localparam int unsigned AW    = reg_aw(NREGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [AW-1:0]     i_ra,
   input  logic [AW-1:0]     i_rb,
   output logic [DATA_W-1:0] o_da,
   output logic [DATA_W-1:0] o_db,
   input  logic              i_we,
   input  logic [AW-1:0]     i_wa,
   input  logic [DATA_W-1:0] i_wd
);

   logic [DATA_W-1:0] r_mem [NREGS];

   logic w_wr_ok;
   assign w_wr_ok = i_we && (i_wa != '0) && (32'(i_wa) < NREGS);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(NREGS); i++) r_mem[i] <= '0;
      end else if (w_wr_ok) begin
         r_mem[i_wa] <= i_wd;
      end
   end

   // Index 0 and out-of-range indices read as zero.
   assign o_da = ((i_ra != '0) && (32'(i_ra) < NREGS)) ? r_mem[i_ra] : '0;
   assign o_db = ((i_rb != '0) && (32'(i_rb) < NREGS)) ? r_mem[i_rb] : '0;

endmodule

// File: rtl/alu_issue.sv
// Two-stage issue/EX front end for an external ALU, with EX->ISSUE forwarding and register preload.
module alu_issue
   import alu_issue_pkg::*;
#(
   parameter  int unsigned NREGS = NREGS_DEF,
   localparam int unsigned AW    = reg_aw(NREGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  op_code_e          in_op_i,
   input  logic [AW-1:0]     in_rd_i,
   input  logic [AW-1:0]     in_rs_i,
   input  logic [AW-1:0]     in_rt_i,
   input  logic              ld_valid_i,
   input  logic [AW-1:0]     ld_rd_i,
   input  logic [DATA_W-1:0] ld_data_i,
   output logic              ld_ready_o,
   output logic [DATA_W-1:0] alu_rs_o,
   output logic [DATA_W-1:0] alu_rt_o,
   output op_code_e          alu_op_o,
   input  logic [DATA_W-1:0] alu_result_i,
   input  logic              alu_zero_i,
   output logic              wb_valid_o,
   output logic [AW-1:0]     wb_rd_o,
   output logic [DATA_W-1:0] wb_data_o,
   output logic              zero_flag_o
);

   logic          r_ex_valid;
   logic [AW-1:0] r_ex_rd;

   logic              w_accept;
   logic              w_fwd_rs;
   logic              w_fwd_rt;
   logic [DATA_W-1:0] w_rf_rs;
   logic [DATA_W-1:0] w_rf_rt;
   logic [DATA_W-1:0] w_opnd_rs;
   logic [DATA_W-1:0] w_opnd_rt;
   logic              w_we;
   logic [AW-1:0]     w_wa;
   logic [DATA_W-1:0] w_wd;

   assign in_ready_o = ~ld_valid_i;
   assign ld_ready_o = ~r_ex_valid;
   assign w_accept   = in_valid_i & in_ready_o;

   // Bypass the retiring result; r0 and out-of-range indices never forward.
   assign w_fwd_rs = r_ex_valid && (r_ex_rd == in_rs_i) && (in_rs_i != '0) && (32'(in_rs_i) < NREGS);
   assign w_fwd_rt = r_ex_valid && (r_ex_rd == in_rt_i) && (in_rt_i != '0) && (32'(in_rt_i) < NREGS);
   assign w_opnd_rs = w_fwd_rs ? alu_result_i : w_rf_rs;
   assign w_opnd_rt = w_fwd_rt ? alu_result_i : w_rf_rt;

   // EX retirement owns the write port; a preload is only accepted when EX is empty.
   assign w_we = r_ex_valid | (ld_valid_i & ld_ready_o);
   assign w_wa = r_ex_valid ? r_ex_rd : ld_rd_i;
   assign w_wd = r_ex_valid ? alu_result_i : ld_data_i;

   reg_file #(.NREGS(NREGS)) u_reg_file (
      .clk   (clk),
      .rst_n (rst_n),
      .i_ra  (in_rs_i),
      .i_rb  (in_rt_i),
      .o_da  (w_rf_rs),
      .o_db  (w_rf_rt),
      .i_we  (w_we),
      .i_wa  (w_wa),
      .i_wd  (w_wd)
   );

   // Issue -> EX stage register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ex_valid <= 1'b0;
         r_ex_rd    <= '0;
         alu_rs_o   <= '0;
         alu_rt_o   <= '0;
         alu_op_o   <= ALU_OR;
      end else begin
         r_ex_valid <= w_accept;
         if (w_accept) begin
            r_ex_rd  <= in_rd_i;
            alu_rs_o <= w_opnd_rs;
            alu_rt_o <= w_opnd_rt;
            alu_op_o <= in_op_i;
         end
      end
   end

   // Write-back observation and zero flag of the retiring instruction.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wb_valid_o  <= 1'b0;
         wb_rd_o     <= '0;
         wb_data_o   <= '0;
         zero_flag_o <= 1'b0;
      end else begin
         wb_valid_o <= r_ex_valid;
         if (r_ex_valid) begin
            wb_rd_o     <= r_ex_rd;
            wb_data_o   <= alu_result_i;
            zero_flag_o <= alu_zero_i;
         end
      end
   end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue; the bench supplies the downstream ALU.
module tb_alu_issue;
   import alu_issue_pkg::*;

   localparam int unsigned AW = REG_AW;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid_i;
   logic              in_ready_o;
   op_code_e          in_op_i;
   logic [AW-1:0]     in_rd_i, in_rs_i, in_rt_i;
   logic              ld_valid_i;
   logic [AW-1:0]     ld_rd_i;
   logic [31:0]       ld_data_i;
   logic              ld_ready_o;
   logic [31:0]       alu_rs_o, alu_rt_o;
   op_code_e          alu_op_o;
   logic [31:0]       alu_result_i;
   logic              alu_zero_i;
   logic              wb_valid_o;
   logic [AW-1:0]     wb_rd_o;
   logic [31:0]       wb_data_o;
   logic              zero_flag_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_issue dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid_i   (in_valid_i),
      .in_ready_o   (in_ready_o),
      .in_op_i      (in_op_i),
      .in_rd_i      (in_rd_i),
      .in_rs_i      (in_rs_i),
      .in_rt_i      (in_rt_i),
      .ld_valid_i   (ld_valid_i),
      .ld_rd_i      (ld_rd_i),
      .ld_data_i    (ld_data_i),
      .ld_ready_o   (ld_ready_o),
      .alu_rs_o     (alu_rs_o),
      .alu_rt_o     (alu_rt_o),
      .alu_op_o     (alu_op_o),
      .alu_result_i (alu_result_i),
      .alu_zero_i   (alu_zero_i),
      .wb_valid_o   (wb_valid_o),
      .wb_rd_o      (wb_rd_o),
      .wb_data_o    (wb_data_o),
      .zero_flag_o  (zero_flag_o)
   );

   // Downstream ALU sitting above alu_issue.
   always_comb begin
      case (alu_op_o)
         ALU_OR:  alu_result_i = alu_rs_o | alu_rt_o;
         ALU_AND: alu_result_i = alu_rs_o & alu_rt_o;
         ALU_ADD: alu_result_i = alu_rs_o + alu_rt_o;
         default: alu_result_i = alu_rs_o - alu_rt_o;
      endcase
      alu_zero_i = (alu_result_i == 32'd0);
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic issue(input op_code_e op, input int rd, input int rs, input int rt);
      in_valid_i = 1'b1;
      in_op_i    = op;
      in_rd_i    = AW'(rd);
      in_rs_i    = AW'(rs);
      in_rt_i    = AW'(rt);
   endtask

   task automatic preload(input int rd, input logic [31:0] d);
      ld_valid_i = 1'b1;
      ld_rd_i    = AW'(rd);
      ld_data_i  = d;
   endtask

   initial begin
      rst_n = 1'b0; in_valid_i = 1'b0; in_op_i = ALU_OR;
      in_rd_i = '0; in_rs_i = '0; in_rt_i = '0;
      ld_valid_i = 1'b0; ld_rd_i = '0; ld_data_i = '0;

      // Reset state; ready equations hold during reset, handshakes are ignored.
      tick(); tick();
      chk("rst_alu_rs", alu_rs_o, 32'd0);
      chk("rst_alu_rt", alu_rt_o, 32'd0);
      chk("rst_alu_op", 32'(alu_op_o), 32'd0);
      chk("rst_wb_valid", 32'(wb_valid_o), 32'd0);
      chk("rst_zero", 32'(zero_flag_o), 32'd0);
      chk("rst_ld_ready", 32'(ld_ready_o), 32'd1);
      preload(1, 32'd77);
      #1 chk("rst_in_ready_ld", 32'(in_ready_o), 32'd0);
      tick();
      ld_valid_i = 1'b0;
      rst_n = 1'b1;

      // ADD r1,r2,r3 on a cleared file.
      issue(ALU_ADD, 1, 2, 3);
      #1 chk("add_in_ready", 32'(in_ready_o), 32'd1);
      tick();
      in_valid_i = 1'b0;
      chk("add_alu_rs", alu_rs_o, 32'd0);
      chk("add_alu_rt", alu_rt_o, 32'd0);
      chk("add_alu_op", 32'(alu_op_o), 32'(ALU_ADD));
      #1 chk("add_ld_ready_busy", 32'(ld_ready_o), 32'd0);
      tick();
      chk("add_wb_valid", 32'(wb_valid_o), 32'd1);
      chk("add_wb_rd", 32'(wb_rd_o), 32'd1);
      chk("add_wb_data", wb_data_o, 32'd0);
      chk("add_zero", 32'(zero_flag_o), 32'd1);

      // Preload r1=5, r2=3; SUB r3,r1,r2.
      preload(1, 32'd5);
      #1 chk("ld_in_ready", 32'(in_ready_o), 32'd0);
      chk("ld_ld_ready", 32'(ld_ready_o), 32'd1);
      tick();
      preload(2, 32'd3);
      tick();
      ld_valid_i = 1'b0;
      chk("ld_no_wb", 32'(wb_valid_o), 32'd0);
      issue(ALU_SUB, 3, 1, 2);
      tick();
      in_valid_i = 1'b0;
      chk("sub_alu_rs", alu_rs_o, 32'd5);
      chk("sub_alu_rt", alu_rt_o, 32'd3);
      tick();
      chk("sub_wb_rd", 32'(wb_rd_o), 32'd3);
      chk("sub_wb_data", wb_data_o, 32'd2);
      chk("sub_zero", 32'(zero_flag_o), 32'd0);

      // Back-to-back dependent ADDs via forwarding.
      issue(ALU_ADD, 4, 1, 2);
      tick();
      issue(ALU_ADD, 5, 4, 4);
      #1 chk("b2b_in_ready", 32'(in_ready_o), 32'd1);
      tick();
      in_valid_i = 1'b0;
      chk("b2b_alu_rs", alu_rs_o, 32'd8);
      chk("b2b_alu_rt", alu_rt_o, 32'd8);
      chk("b2b_wb4_data", wb_data_o, 32'd8);
      tick();
      chk("b2b_wb5_rd", 32'(wb_rd_o), 32'd5);
      chk("b2b_wb5_data", wb_data_o, 32'd16);

      // OR r0,r1,r2 then ADD r6,r0,r0: no forwarding from r0.
      issue(ALU_OR, 0, 1, 2);
      tick();
      issue(ALU_ADD, 6, 0, 0);
      tick();
      in_valid_i = 1'b0;
      chk("r0_alu_rs", alu_rs_o, 32'd0);
      chk("r0_alu_rt", alu_rt_o, 32'd0);
      chk("r0_wb_valid", 32'(wb_valid_o), 32'd1);
      chk("r0_wb_rd", 32'(wb_rd_o), 32'd0);
      chk("r0_wb_data", wb_data_o, 32'd7);
      tick();
      chk("r6_wb_rd", 32'(wb_rd_o), 32'd6);
      chk("r6_wb_data", wb_data_o, 32'd0);
      chk("r6_zero", 32'(zero_flag_o), 32'd1);

      // Preload r7=9 while EX is busy: held off one cycle.
      issue(ALU_ADD, 3, 1, 2);
      tick();
      in_valid_i = 1'b0;
      preload(7, 32'd9);
      #1 chk("ldbusy_ld_ready", 32'(ld_ready_o), 32'd0);
      chk("ldbusy_in_ready", 32'(in_ready_o), 32'd0);
      tick();
      chk("ldfree_ld_ready", 32'(ld_ready_o), 32'd1);
      tick();
      ld_valid_i = 1'b0;
      issue(ALU_ADD, 1, 7, 0);
      tick();
      in_valid_i = 1'b0;
      chk("r7_alu_rs", alu_rs_o, 32'd9);
      chk("r7_alu_rt", alu_rt_o, 32'd0);
      tick();
      chk("r7_wb_data", wb_data_o, 32'd9);

      // Reset during EX of ADD r2,r1,r1 discards it.
      issue(ALU_ADD, 2, 1, 1);
      tick();
      in_valid_i = 1'b0;
      chk("rex_alu_rs", alu_rs_o, 32'd9);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("rex_wb_valid", 32'(wb_valid_o), 32'd0);
      tick();
      chk("rex_wb_valid2", 32'(wb_valid_o), 32'd0);
      issue(ALU_ADD, 3, 2, 1);
      tick();
      in_valid_i = 1'b0;
      chk("rex_r2_after", alu_rs_o, 32'd0);
      chk("rex_r1_after", alu_rt_o, 32'd0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have one clock and synchronous, active-low reset; all state changes on rising clk.
REQ-002 Parameter: NREGS, default 8, number of 32-bit architectural registers (REG_AW = log2(NREGS)).
REQ-003 clk  in  1  clock.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 in_valid_i  in  1  instruction offered.
REQ-006 in_ready_o  out  1  instruction accepted when in_valid_i & in_ready_o.
REQ-007 in_op_i  in  op_code  ALU operation (ALU_OR/AND/ADD/SUB).
REQ-008 in_rd_i / in_rs_i / in_rt_i  in  REG_AW each  destination / source register indices.
REQ-009 ld_valid_i  in  1, ld_rd_i  in  REG_AW, ld_data_i  in  32  external register preload request.
REQ-010 ld_ready_o  out  1  preload accepted when ld_valid_i & ld_ready_o.
REQ-011 alu_rs_o, alu_rt_o  out  32, alu_op_o  out  op_code  registered operands/op driven into the downstream ALU.
REQ-012 alu_result_i  in  32, alu_zero_i  in  1  combinational ALU response to current alu_* outputs.
REQ-013 wb_valid_o  out  1, wb_rd_o  out  REG_AW, wb_data_o  out  32  registered write-back observation.
REQ-014 zero_flag_o  out  1  zero flag of last retired instruction.

Function
REQ-015 Two stages: ISSUE (accept, read operands) and EX (alu_* outputs held, result captured); ex_valid marks EX occupied.
REQ-016 Accepted in cycle N -> alu_rs_o/alu_rt_o/alu_op_o valid, ex_valid=1 in cycle N+1; regfile write of alu_result_i at edge ending N+1; wb_valid_o=1 with rd/data in N+2.
REQ-017 in_ready_o = ~ld_valid_i; no other backpressure (EX always retires in one cycle).
REQ-018 ld_ready_o = ~ex_valid; preload writes regfile at that edge; preload never shares a write edge with EX retirement.
REQ-019 Forwarding: if ex_valid and ex_rd == source index != 0, operand SHALL be alu_result_i, not regfile content; applies to rs and rt independently.
REQ-020 Register 0 SHALL read as 0; writes to index 0 (EX or preload) discarded; wb_valid_o still pulses with wb_rd_o=0.
REQ-021 No accept in cycle -> ex_valid=0 next cycle; alu_* outputs hold previous values.
REQ-022 zero_flag_o updated from alu_zero_i only at EX retirement; held otherwise.
REQ-023 Back-to-back dependent instructions SHALL issue every cycle with no stall.
REQ-024 Indices >= NREGS: reads return 0, writes discarded.

Reset
REQ-025 While rst_n=0 at an edge: all registers, alu_rs_o, alu_rt_o, wb_data_o, wb_rd_o := 0; alu_op_o := encoding 0; ex_valid, wb_valid_o, zero_flag_o := 0.
REQ-026 Reset during EX discards in-flight instruction: no regfile write, no wb_valid_o pulse.
REQ-027 in_ready_o and ld_ready_o follow their equations during reset; accepted handshakes during reset have no effect.

Structure
REQ-028 op_code enum, NREGS default and REG_AW SHALL live in the shared definitions package.
REQ-029 Register array SHALL be sub-module reg_file (2 read, 1 write, r0 hardwired zero); forwarding and EX register stay in alu_issue.
REQ-030 ALU not instantiated inside alu_issue; connected at the level above.

Verification
REQ-031 Reset, issue ADD r1,r2,r3 -> next cycle alu_rs_o=0, alu_rt_o=0; two cycles later wb_valid_o=1, wb_rd_o=1, wb_data_o=0, zero_flag_o=1.
REQ-032 Preload r1=5, r2=3; SUB r3,r1,r2 -> alu operands 5,3; wb r3=2, zero_flag_o=0.
REQ-033 Back-to-back ADD r4,r1,r2 then ADD r5,r4,r4 -> second EX operands 8,8 via forwarding; wb r5=16; in_ready_o never low.
REQ-034 OR r0,r1,r2 then ADD r6,r0,r0 -> r6 operands 0,0 (no forward from r0); wb r6=0.
REQ-035 ld_valid_i (r7=9) asserted while ex_valid=1 -> ld_ready_o=0, in_ready_o=0 that cycle; next cycle preload accepted; later read of r7 gives 9.
REQ-036 rst_n low during EX of ADD r2,r1,r1 -> no wb_valid_o; after reset r2 reads 0.
